// File: rtl/id_issue_queue.sv
// Purpose : in-order issue queue between NR_PORTS decoders and the issue stage.
// Latency : write-to-output 1 cycle (0 cycles from port 0 when ID_ISSUE_QUEUE_BYPASS_EN is defined).
// Backpressure: in_ready_o[i] drops once fewer than i+1 slots are free (a same-cycle ack frees one).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop all entries, refuse writes this cycle
//   in_valid_i/_entry_i/_ctrl_flow_i/in_ready_o   NR_PORTS-wide write side, port 0 oldest
//   out_entry_o/_valid_o/_ctrl_flow_o, out_ack_i  oldest entry with valid/ack handshake
//   count_o                current occupancy
// Optional build macro: ID_ISSUE_QUEUE_BYPASS_EN (port 0 passes straight to the output when empty).
// DATA_W is normally set by the core to the width of its scoreboard entry.
module id_issue_queue #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NR_PORTS-1:0]          in_valid_i,
    input  logic [NR_PORTS*DATA_W-1:0]   in_entry_i,
    input  logic [NR_PORTS-1:0]          in_ctrl_flow_i,
    output logic [NR_PORTS-1:0]          in_ready_o,
    output logic [DATA_W-1:0]            out_entry_o,
    output logic                         out_valid_o,
    output logic                         out_ctrl_flow_o,
    input  logic                         out_ack_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for DEPTH+1 free slots and for pointer sums up to 2*DEPTH-1.
    localparam int unsigned SUM_W = $clog2(2 * DEPTH + 2);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W:0]   mem_q [DEPTH];   // {ctrl_flow, entry}

    logic              byp_vld;         // port 0 is shown on the output this cycle
    logic              byp_take;        // port 0 is consumed without being stored
    logic              pop;
    logic              pop_mem;
    logic [SUM_W-1:0]  free_slots;
    logic [SUM_W-1:0]  n_acc;
    logic [SUM_W-1:0]  n_store;
    logic [SUM_W-1:0]  cnt_sum;
    logic [NR_PORTS-1:0] accept;
    logic [NR_PORTS-1:0] we;
    logic [PTR_W-1:0]  waddr [NR_PORTS];

    // Modulo-DEPTH pointer advance; k < DEPTH+1 so a single subtraction wraps.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [SUM_W-1:0] k);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + k;
        if (s >= SUM_W'(DEPTH)) begin
            s = s - SUM_W'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    assign byp_vld = rst_ni & ~flush_i & (count_q == '0) & in_valid_i[0];
`else
    assign byp_vld = 1'b0;
`endif
    assign byp_take = byp_vld & out_ack_i;

    // Valid is deliberately not masked by flush in the flush cycle itself.
    assign out_valid_o     = (count_q != '0) | byp_vld;
    assign out_entry_o     = byp_vld ? in_entry_i[DATA_W-1:0] : mem_q[head_q][DATA_W-1:0];
    assign out_ctrl_flow_o = byp_vld ? in_ctrl_flow_i[0]      : mem_q[head_q][DATA_W];
    assign count_o         = count_q;

    assign pop     = out_ack_i & out_valid_o;
    // A bypass-consumed entry never occupied storage, so the head does not move for it.
    assign pop_mem = pop & ~byp_take;
    // An ack in the same cycle frees a slot, so writes proceed while full.
    assign free_slots = SUM_W'(DEPTH) - SUM_W'(count_q) + SUM_W'(pop);

    always_comb begin
        in_ready_o = '0;
        accept     = '0;
        we         = '0;
        n_acc      = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            waddr[i] = '0;
        end
        for (int i = 0; i < NR_PORTS; i++) begin
            // Reset gating keeps fetch from seeing an acknowledge while held in reset.
            in_ready_o[i] = rst_ni & ~flush_i & (free_slots > SUM_W'(i));
            accept[i]     = in_valid_i[i] & in_ready_o[i];
            n_acc         = n_acc + SUM_W'(accept[i]);
        end
        // Ports are a contiguous prefix, so accepted port i lands i slots past the tail
        // (one less when port 0 went straight to issue).
        for (int i = 0; i < NR_PORTS; i++) begin
            if (i == 0) begin
                we[i]    = accept[i] & ~byp_take;
                waddr[i] = tail_q;
            end else begin
                we[i]    = accept[i];
                waddr[i] = ptr_add(tail_q, SUM_W'(i) - SUM_W'(byp_take));
            end
        end
    end

    assign n_store = n_acc - SUM_W'(byp_take);
    assign cnt_sum = SUM_W'(count_q) + n_store - SUM_W'(pop_mem);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = ptr_add(head_q, SUM_W'(pop_mem));
            tail_d  = ptr_add(tail_q, n_store);
            count_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // flush_i drops in_ready_o, so no write enable is set during a flush.
            for (int i = 0; i < NR_PORTS; i++) begin
                if (we[i]) begin
                    mem_q[waddr[i]] <= {in_ctrl_flow_i[i], in_entry_i[i*DATA_W +: DATA_W]};
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Valid ports must form a prefix starting at port 0.
    a_valid_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_valid_i & (in_valid_i + NR_PORTS'(1))) == '0);
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(DEPTH));
`endif

endmodule
